instr_mem_loader: RTL and testbench

Byte-stream program loader that writes the CPU's 64-word instruction memory. Receives a header byte plus little-endian instruction bytes over a valid/ready stream, assembles 32-bit words and issues one write per word at incrementing word addresses. Holds the CPU stalled while loading. Sits between the host/debug byte source and the write port of the instruction memory.

---
 rtl/instr_mem_loader.sv | 173 +++++++++++++++++
 tb/tb_instr_mem_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Purpose : byte-stream loader that fills the CPU instruction memory (header = word count, then LE words).
// Latency : 4th byte of a word accepted at edge t -> wr_en high during cycle t+1; 5 cycles/word streaming.
// Backpressure: in_ready is registered and depends only on state; it drops for the one-cycle write slot.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start               begin a load (only honoured in IDLE or DONE)
//   in_valid/in_data    byte stream source, in_ready = loader accepts a byte this cycle
//   wr_en/wr_addr/wr_data  one-cycle instruction memory write port
//   busy                load in progress (drives CPU hold)
//   done                load complete (level)
//   err                 checksum mismatch (level)
// Optional feature: define LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte
// after the last word; otherwise err is tied low and the last write ends the load.

module instr_mem_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    BYTES,
    WRITE,
`ifdef LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE
  } state_t;

  state_t            state;
  logic [1:0]        byte_idx;
  logic [23:0]       word_buf;   // lower three bytes of the word being assembled
  logic [ADDR_W-1:0] last_addr;  // address of the final word of this load
  logic              take;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`else
  assign err = 1'b0;
`endif

  // in_ready is a register, so this is a pure AND with no path back to in_valid.
  assign take = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      byte_idx  <= '0;
      word_buf  <= '0;
      last_addr <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum      <= '0;
      err       <= 1'b0;
`endif
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= HDR;
            busy     <= 1'b1;
            in_ready <= 1'b1;
            done     <= 1'b0;
            byte_idx <= '0;
            wr_addr  <= '0;
`ifdef LOADER_CHECKSUM_EN
            err      <= 1'b0;
            csum     <= '0;
`endif
          end
        end

        HDR: begin
          if (take) begin
            // A count of 0 (or anything beyond the memory) means a full-depth
            // load, so the address never has to wrap.
            if (in_data == 8'd0 || int'(in_data) > DEPTH) begin
              last_addr <= '1;
            end else begin
              last_addr <= ADDR_W'(in_data - 8'd1);
            end
            state <= BYTES;
`ifdef LOADER_CHECKSUM_EN
            csum  <= csum ^ in_data;
`endif
          end
        end

        BYTES: begin
          if (take) begin
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ in_data;
`endif
            if (byte_idx == 2'd3) begin
              // Last byte goes straight into the output word; wr_data then
              // holds until the next word completes.
              wr_data  <= {in_data, word_buf};
              wr_en    <= 1'b1;
              in_ready <= 1'b0;
              byte_idx <= '0;
              state    <= WRITE;
            end else begin
              case (byte_idx)
                2'd0:    word_buf[7:0]   <= in_data;
                2'd1:    word_buf[15:8]  <= in_data;
                default: word_buf[23:16] <= in_data;
              endcase
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end

        WRITE: begin
          if (wr_addr == last_addr) begin
`ifdef LOADER_CHECKSUM_EN
            state    <= CHK;
            in_ready <= 1'b1;
`else
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
`endif
          end else begin
            wr_addr  <= wr_addr + ADDR_W'(1);
            in_ready <= 1'b1;
            state    <= BYTES;
          end
        end

`ifdef LOADER_CHECKSUM_EN
        CHK: begin
          if (take) begin
            err      <= (in_data != csum);
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
`endif

        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Purpose : self-checking bench for instr_mem_loader (random loads vs. a queue-based reference).
// Latency : checks start-to-done cycle count for unstalled loads.
// Backpressure: drives in_valid stalls (none / alternating / random) and pokes start while busy.

module tb_instr_mem_loader;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          busy;
  logic          done;
  logic          err;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [7:0]      data_q[$];
  logic [7:0]      stream_q[$];
  logic [AW+31:0]  exp_q[$];
  logic [AW+31:0]  obs_q[$];

  instr_mem_loader #(.ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Record every write strobe; the write slot must never also offer in_ready.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      obs_q.push_back({wr_addr, wr_data});
      check("rdy_in_wr", 64'(in_ready), 64'd0);
    end
  end

  task automatic compare_writes();
    int n;
    check("n_writes", 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check("write", 64'(obs_q[i]), 64'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  // mode 0: in_valid held high, 1: one idle cycle before every byte, 2: random idles.
  task automatic send_bytes(input int mode, input bit poke);
    int guard;
    for (int i = 0; i < stream_q.size(); i++) begin
      if (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        start    = poke ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = stream_q[i];
      start    = poke ? ($urandom_range(0, 3) == 0) : 1'b0;
      guard    = 0;
      while (!in_ready && guard < 100) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 100) begin
        check("rdy_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        start    = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Reference: word k = bytes 4k..4k+3 little-endian at address k; checksum = XOR of header+data.
  task automatic do_load(input logic [7:0] hdr, input int mode, input bit poke, input logic [7:0] bad_mask);
    int         words, c0, guard, exp_cyc;
    logic [7:0] x;
    logic       exp_err;
    words = (hdr == 8'd0) ? (1 << AW) : int'(hdr);
    x = hdr;
    stream_q.delete();
    stream_q.push_back(hdr);
    foreach (data_q[i]) begin
      stream_q.push_back(data_q[i]);
      x ^= data_q[i];
    end
    for (int k = 0; k < words; k++)
      exp_q.push_back({AW'(k), data_q[4*k+3], data_q[4*k+2], data_q[4*k+1], data_q[4*k]});
    exp_cyc = 2 + 5 * words;
`ifdef LOADER_CHECKSUM_EN
    stream_q.push_back(x ^ bad_mask);
    exp_err = (bad_mask != 8'd0);
    exp_cyc = exp_cyc + 1;
`else
    exp_err = 1'b0;
`endif
    c0 = cyc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_t1", 64'(busy), 64'd1);
    check("rdy_t1", 64'(in_ready), 64'd1);
    check("done_clr", 64'(done), 64'd0);
    check("err_clr", 64'(err), 64'd0);
    send_bytes(mode, poke);
    guard = 0;
    while (!done && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check("done", 64'(done), 64'd1);
    if (mode == 0) check("cycles", 64'(cyc - c0), 64'(exp_cyc));
    check("busy_end", 64'(busy), 64'd0);
    check("rdy_end", 64'(in_ready), 64'd0);
    check("err", 64'(err), 64'(exp_err));
    repeat (3) @(posedge clk);
    #1;
    compare_writes();
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'($urandom);

    // Reset held with traffic present: everything low, no writes.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("rst_outs", 64'({in_ready, wr_en, wr_addr, wr_data, busy, done, err}), 64'd0);
      in_data = 8'($urandom);
    end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_outs", 64'({in_ready, busy, done, err}), 64'd0);
    check("rst_nowr", 64'(obs_q.size()), 64'd0);

    // Single word 0x00002083, correct checksum.
    data_q = '{8'h83, 8'h20, 8'h00, 8'h00};
    do_load(8'h01, 0, 1'b0, 8'h00);

    // Same word, checksum byte 0x00 instead of 0xA2 (only meaningful with the checksum build).
    do_load(8'h01, 0, 1'b0, 8'hA2);

    // Back-pressure: two words with in_valid toggling.
    data_q.delete();
    repeat (8) data_q.push_back(8'($urandom));
    do_load(8'h02, 1, 1'b0, 8'h00);

    // Full depth: header 0, word k = k.
    data_q.delete();
    for (int k = 0; k < (1 << AW); k++) begin
      data_q.push_back(8'(k));
      data_q.push_back(8'h00);
      data_q.push_back(8'h00);
      data_q.push_back(8'h00);
    end
    do_load(8'h00, 0, 1'b0, 8'h00);

    // Reset after two bytes of word 3: only words 0..2 are written.
    data_q.delete();
    repeat (14) data_q.push_back(8'($urandom));
    stream_q.delete();
    stream_q.push_back(8'h05);
    foreach (data_q[i]) stream_q.push_back(data_q[i]);
    for (int k = 0; k < 3; k++)
      exp_q.push_back({AW'(k), data_q[4*k+3], data_q[4*k+2], data_q[4*k+1], data_q[4*k]});
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send_bytes(0, 1'b0);
    in_valid = 1'b1;
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    repeat (10) begin
      in_data = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    compare_writes();

    // Fresh load after the aborted one starts again at address 0.
    data_q.delete();
    repeat (4) data_q.push_back(8'($urandom));
    do_load(8'h01, 2, 1'b0, 8'h00);

    // Random loads: random sizes, stalls, stray start pulses and checksum faults.
    for (int it = 0; it < 10; it++) begin
      int         n;
      int         mode;
      bit         poke;
      logic [7:0] mask;
      n    = $urandom_range(1, 10);
      mode = $urandom_range(0, 2);
      poke = 1'($urandom_range(0, 1));
      mask = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
      data_q.delete();
      repeat (4 * n) data_q.push_back(8'($urandom));
      do_load(8'(n), mode, poke, mask);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
